// File: rtl/grn_floyd_ctrl_if.sv
// Handshake bundle between the host/node array and the Floyd cycle-detection controller.
// The master side is the host plus node array; the slave side is the controller.
interface grn_floyd_ctrl_if #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
);
  logic               start;
  logic [N_NODES-1:0] init_in;
  logic [CNT_W-1:0]   max_steps;
  logic [N_NODES-1:0] s0_vec;
  logic [N_NODES-1:0] s1_vec;
  logic               reset_nos;
  logic [N_NODES-1:0] init_state;
  logic               start_s0;
  logic               start_s1;
  logic               busy;
  logic               done;
  logic               timeout;
  logic [CNT_W-1:0]   meet_steps;
  logic [CNT_W-1:0]   period;
  logic [N_NODES-1:0] attractor;

  modport master (
    output start, init_in, max_steps, s0_vec, s1_vec,
    input  reset_nos, init_state, start_s0, start_s1, busy, done, timeout,
           meet_steps, period, attractor
  );

  modport slave (
    input  start, init_in, max_steps, s0_vec, s1_vec,
    output reset_nos, init_state, start_s0, start_s1, busy, done, timeout,
           meet_steps, period, attractor
  );
endinterface

// File: rtl/grn_floyd_ctrl.sv
// Floyd tortoise/hare controller for one GRN node bank.
// It finds the attractor of the network trajectory and then measures its period.
module grn_floyd_ctrl #(
  parameter int N_NODES = 8,
  parameter int CNT_W   = 16
) (
  input logic            clk,
  input logic            rst,
  grn_floyd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PER, DONE} state_e;

  state_e             state_q, state_d;
  logic [N_NODES-1:0] init_state_q, init_state_d;
  logic [N_NODES-1:0] attractor_q, attractor_d;
  logic [CNT_W-1:0]   meet_steps_q, meet_steps_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   p_q, p_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  logic hit;
  logic match;
  logic accept;

  // The hare leads by exactly twice the tortoise's steps only on even k.
  assign hit   = (k_q >= CNT_W'(2)) && !k_q[0] && (bus.s0_vec == bus.s1_vec);
  assign match = (p_q != '0) && (bus.s1_vec == bus.s0_vec);
  // The first DONE cycle has done still low, so a start there is dropped.
  assign accept = bus.start && ((state_q == IDLE) || ((state_q == DONE) && done_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      init_state_q <= '0;
      attractor_q  <= '0;
      meet_steps_q <= '0;
      period_q     <= '0;
      k_q          <= '0;
      p_q          <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_state_q <= init_state_d;
      attractor_q  <= attractor_d;
      meet_steps_q <= meet_steps_d;
      period_q     <= period_d;
      k_q          <= k_d;
      p_q          <= p_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_state_d = init_state_q;
    attractor_d  = attractor_q;
    meet_steps_d = meet_steps_q;
    period_d     = period_q;
    k_d          = k_q;
    p_d          = p_q;
    done_d       = done_q;
    timeout_d    = timeout_q;

    if (accept) begin
      init_state_d = bus.init_in;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
      state_d      = LOAD;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          k_d     = '0;
          state_d = RUN;
        end
        RUN: begin
          if (hit) begin
            meet_steps_d = k_q;
            attractor_d  = bus.s0_vec;
            p_d          = '0;
            state_d      = PER;
          end else if (k_q == bus.max_steps) begin
            timeout_d = 1'b1;
            period_d  = '0;
            state_d   = DONE;
          end else begin
            k_d = k_q + CNT_W'(1);
          end
        end
        PER: begin
          if (match) begin
            period_d = p_q;
            state_d  = DONE;
          end else if (p_q == bus.max_steps) begin
            timeout_d = 1'b1;
            period_d  = '0;
            state_d   = DONE;
          end else begin
            p_d = p_q + CNT_W'(1);
          end
        end
        DONE: done_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  // Step strobes are withheld in the detection cycle so the vectors stay frozen.
  always_comb begin
    bus.reset_nos = 1'b0;
    bus.start_s0  = 1'b0;
    bus.start_s1  = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      LOAD: begin
        bus.reset_nos = 1'b1;
        bus.busy      = 1'b1;
      end
      RUN: begin
        bus.start_s0 = !hit;
        bus.start_s1 = !hit;
        bus.busy     = 1'b1;
      end
      PER: begin
        bus.start_s1 = !match;
        bus.busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.init_state = init_state_q;
  assign bus.attractor  = attractor_q;
  assign bus.meet_steps = meet_steps_q;
  assign bus.period     = period_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_grn_floyd_ctrl.sv
// Bench for grn_floyd_ctrl: a node-bank model driven by a table-based next-state map,
// with results compared against a trajectory-level model of Floyd detection.
module tb_grn_floyd_ctrl;

  logic clk;
  logic rst;

  grn_floyd_ctrl_if #(.N_NODES(8), .CNT_W(16)) bus ();

  grn_floyd_ctrl #(.N_NODES(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Next-state map acts on the low nibble; the high nibble is carried unchanged.
  logic [3:0] fTab [16];

  function automatic logic [7:0] fStep(input logic [7:0] x);
    return {x[7:4], fTab[x[3:0]]};
  endfunction

  function automatic logic [7:0] fPow(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = fStep(y);
    return y;
  endfunction

  // Node bank: hare steps every enabled cycle, tortoise on every other enabled cycle.
  logic [7:0] s0Node, s1Node;
  logic       s0Phase;

  always @(posedge clk) begin
    if (bus.reset_nos) begin
      s0Node  <= bus.init_state;
      s1Node  <= bus.init_state;
      s0Phase <= 1'b0;
    end else begin
      if (bus.start_s1) s1Node <= fStep(s1Node);
      if (bus.start_s0) begin
        if (!s0Phase) s0Node <= fStep(s0Node);
        s0Phase <= ~s0Phase;
      end
    end
  end

  assign bus.s0_vec = s0Node;
  assign bus.s1_vec = s1Node;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: search the trajectory directly for x_m == x_2m, then for the cycle length.
  task automatic modelJob(input logic [7:0] x, input int maxS,
                          output bit to, output int meet, output int per,
                          output logic [7:0] att, output int lat,
                          output int s1, output int s0);
    to = 1'b1; meet = 0; per = 0; att = '0;
    for (int m = 1; 2 * m <= maxS; m++) begin
      if (fPow(x, m) == fPow(x, 2 * m)) begin
        meet = 2 * m;
        to   = 1'b0;
        break;
      end
    end
    if (to) begin
      s1  = maxS + 1;
      s0  = maxS + 1;
      lat = 3 + maxS + 1;
    end else begin
      att = fPow(x, meet / 2);
      s0  = meet;
      for (int l = 1; l <= maxS; l++) begin
        if (fPow(att, l) == att) begin
          per = l;
          break;
        end
      end
      if (per == 0) begin
        to  = 1'b1;
        s1  = meet + maxS + 1;
        lat = 3 + (meet + 1) + (maxS + 1);
      end else begin
        s1  = meet + per;
        lat = 3 + (meet + 1) + (per + 1);
      end
    end
  endtask

  int obsLat, obsS1, obsS0, obsRn;

  // Launches one job and measures latency and strobe counts until done is seen.
  task automatic applyStimulus(input logic [7:0] init, input int maxS,
                               input bit pokeBusy, input bit pokeEntry);
    obsLat = 0; obsS1 = 0; obsS0 = 0; obsRn = 0;
    @(negedge clk);
    bus.init_in   = init;
    bus.max_steps = 16'(maxS);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("load_done_low", 32'(bus.done), 32'd0);
    checkOutput("load_init_state", 32'(bus.init_state), 32'(init));
    checkOutput("load_reset_nos", 32'(bus.reset_nos), 32'd1);
    for (int c = 1; c <= 2000; c++) begin
      if (bus.start_s1)  obsS1++;
      if (bus.start_s0)  obsS0++;
      if (bus.reset_nos) obsRn++;
      if (bus.done) begin
        obsLat = c;
        break;
      end
      bus.start = 1'b0;
      if (pokeBusy && c == 3) begin
        bus.start   = 1'b1;
        bus.init_in = ~init;
      end
      if (pokeEntry && !bus.busy && c > 1) begin
        bus.start   = 1'b1;
        bus.init_in = ~init;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (obsLat == 0) checkOutput("done_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic checkJob(input string tag, input logic [7:0] init, input int maxS);
    bit         to;
    int         meet, per, lat, s1, s0;
    logic [7:0] att;
    modelJob(init, maxS, to, meet, per, att, lat, s1, s0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd1);
    checkOutput({tag, "_timeout"}, 32'(bus.timeout), 32'(to));
    checkOutput({tag, "_period"}, 32'(bus.period), 32'(per));
    if (!to) begin
      checkOutput({tag, "_meet"}, 32'(bus.meet_steps), 32'(meet));
      checkOutput({tag, "_attractor"}, 32'(bus.attractor), 32'(att));
    end
    checkOutput({tag, "_latency"}, 32'(obsLat), 32'(lat));
    checkOutput({tag, "_s1_steps"}, 32'(obsS1), 32'(s1));
    checkOutput({tag, "_s0_steps"}, 32'(obsS0), 32'(s0));
    checkOutput({tag, "_init_state"}, 32'(bus.init_state), 32'(init));
    @(negedge clk);
    checkOutput({tag, "_idle_strobes"},
                32'({bus.reset_nos, bus.start_s0, bus.start_s1, bus.busy}), 32'd0);
    checkOutput({tag, "_done_held"}, 32'(bus.done), 32'd1);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.init_in   = '0;
    bus.max_steps = '0;
    rst           = 1'b0;
    for (int i = 0; i < 16; i++) fTab[i] = 4'(i);
    repeat (3) @(negedge clk);
    checkOutput("rst_state",
                32'({bus.reset_nos, bus.start_s0, bus.start_s1, bus.busy, bus.done, bus.timeout}),
                32'd0);
    checkOutput("rst_results", 32'({bus.meet_steps, bus.period}), 32'd0);
    checkOutput("rst_vectors", 32'({bus.attractor, bus.init_state}), 32'd0);
    rst = 1'b1;

    // Fixed point: detection at k=2, period 1.
    applyStimulus(8'h5A, 100, 1'b0, 1'b0);
    checkJob("ident", 8'h5A, 100);
    checkOutput("ident_plan_meet", 32'(bus.meet_steps), 32'd2);
    checkOutput("ident_plan_period", 32'(bus.period), 32'd1);
    checkOutput("ident_plan_attr", 32'(bus.attractor), 32'h5A);
    checkOutput("ident_plan_latency", 32'(obsLat), 32'd8);

    // Pure 16-cycle.
    for (int i = 0; i < 16; i++) fTab[i] = 4'((i + 1) % 16);
    applyStimulus(8'h00, 100, 1'b0, 1'b0);
    checkJob("incr", 8'h00, 100);
    checkOutput("incr_plan_meet", 32'(bus.meet_steps), 32'd32);
    checkOutput("incr_plan_period", 32'(bus.period), 32'd16);
    checkOutput("incr_plan_s1", 32'(obsS1), 32'd48);

    // Step bound reached in RUN.
    applyStimulus(8'h00, 20, 1'b0, 1'b0);
    checkJob("incr_bound", 8'h00, 20);
    checkOutput("incr_bound_plan_to", 32'(bus.timeout), 32'd1);
    checkOutput("incr_bound_plan_s1", 32'(obsS1), 32'd21);

    // Abort in the middle of RUN (k=7 is the ninth cycle after the start cycle).
    @(negedge clk);
    bus.init_in   = 8'h00;
    bus.max_steps = 16'd100;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("abort_pre_busy", 32'({bus.busy, bus.start_s1}), 32'd3);
    #1 rst = 1'b0;
    #1;
    checkOutput("abort_strobes",
                32'({bus.reset_nos, bus.start_s0, bus.start_s1, bus.busy, bus.done, bus.timeout}),
                32'd0);
    checkOutput("abort_results", 32'({bus.meet_steps, bus.period}), 32'd0);
    checkOutput("abort_vectors", 32'({bus.attractor, bus.init_state}), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Transient 0->1->2->3->2 after the abort, with one reload pulse.
    for (int i = 0; i < 16; i++) fTab[i] = 4'(i);
    fTab[0] = 4'd1; fTab[1] = 4'd2; fTab[2] = 4'd3; fTab[3] = 4'd2;
    applyStimulus(8'h00, 100, 1'b0, 1'b0);
    checkJob("trans", 8'h00, 100);
    checkOutput("trans_plan_meet", 32'(bus.meet_steps), 32'd4);
    checkOutput("trans_plan_period", 32'(bus.period), 32'd2);
    checkOutput("trans_plan_attr", 32'(bus.attractor), 32'd2);
    checkOutput("trans_reload_pulses", 32'(obsRn), 32'd1);

    // Start while busy is dropped, start in the DONE entry cycle is dropped.
    applyStimulus(8'h01, 100, 1'b1, 1'b1);
    checkJob("poke", 8'h01, 100);
    checkOutput("poke_reload_pulses", 32'(obsRn), 32'd1);

    // Tiny step bounds time out in RUN.
    applyStimulus(8'h03, 0, 1'b0, 1'b0);
    checkJob("max0", 8'h03, 0);
    applyStimulus(8'h03, 1, 1'b0, 1'b0);
    checkJob("max1", 8'h03, 1);

    // Random maps, seeds and bounds.
    for (int j = 0; j < 20; j++) begin
      logic [7:0] rInit;
      int         rMax;
      for (int i = 0; i < 16; i++) fTab[i] = 4'($urandom_range(0, 15));
      rInit = 8'($urandom_range(0, 255));
      rMax  = $urandom_range(0, 40);
      applyStimulus(rInit, rMax, 1'($urandom_range(0, 1)), 1'b0);
      checkJob("rand", rInit, rMax);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
